// File: rtl/fp_special_pack.sv
// Packs a classified floating-point result (special code, sign, wide exponent, mantissa)
// into an IEEE word through a two-stage valid/ready pipeline.

`ifndef FP32
`define FP32 0
`endif
`ifndef FP64
`define FP64 1
`endif
`ifndef GET_FP_LEN
`define GET_FP_LEN(f) (((f) == `FP64) ? 64 : 32)
`endif
`ifndef GET_EXP_LEN
`define GET_EXP_LEN(f) (((f) == `FP64) ? 11 : 8)
`endif
`ifndef NORMAL
`define NORMAL 2'd0
`endif
`ifndef ZERO
`define ZERO 2'd1
`endif
`ifndef INF
`define INF 2'd2
`endif
`ifndef NAN
`define NAN 2'd3
`endif

module fp_special_pack #(
  parameter int data_format = `FP32,
  localparam int FP_W  = `GET_FP_LEN(data_format),
  localparam int EXP_W = `GET_EXP_LEN(data_format),
  localparam int MAN_W = FP_W - EXP_W - 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         in_special,
  input  logic               in_sign,
  input  logic [EXP_W+1:0]   in_exp,
  input  logic [MAN_W:0]     in_mant,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [FP_W-1:0]    out_data,
  output logic [2:0]         out_flags
);

  // Handshake: a beat moves on a port when valid & ready are both high at the rising edge.
  // in_ready depends only on pipeline occupancy and out_ready, never on in_valid.

  localparam logic signed [EXP_W+1:0] EXP_MAX = $signed({2'b00, {EXP_W{1'b1}}});

  logic               s1_valid;
  logic [FP_W-1:0]    s1_data;
  logic [2:0]         s1_flags;
  logic               out_adv;
  logic               s1_adv;
  logic [FP_W-1:0]    pk_data;
  logic [2:0]         pk_flags;
  logic signed [EXP_W+1:0] exp_s;

  assign out_adv  = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || out_adv;
  assign in_ready = s1_adv;
  assign exp_s    = $signed(in_exp);

  // Flags are {invalid, overflow, underflow}; range checks use the full signed exponent.
  always_comb begin
    pk_data  = '0;
    pk_flags = 3'b000;
    case (in_special)
      `NAN: begin
        pk_data  = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
        pk_flags = 3'b100;
      end
      `INF:  pk_data = {in_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      `ZERO: pk_data = {in_sign, {(FP_W-1){1'b0}}};
      default: begin
        if (in_mant == '0) begin
          pk_data = {in_sign, {(FP_W-1){1'b0}}};
        end else if (exp_s >= EXP_MAX) begin
          pk_data  = {in_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          pk_flags = 3'b010;
        end else if (exp_s <= 0) begin
          pk_data  = {in_sign, {(FP_W-1){1'b0}}};
          pk_flags = 3'b001;
        end else begin
          pk_data = {in_sign, in_exp[EXP_W-1:0], in_mant[MAN_W-1:0]};
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_data   <= '0;
      s1_flags  <= 3'b000;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_flags <= 3'b000;
    end else begin
      if (out_adv) begin
        out_valid <= s1_valid;
        out_data  <= s1_data;
        out_flags <= s1_flags;
      end
      if (s1_adv) begin
        s1_valid <= in_valid;
        s1_data  <= pk_data;
        s1_flags <= pk_flags;
      end
    end
  end

endmodule

// File: tb/tb_fp_special_pack.sv
// Randomized and directed bench for fp_special_pack (FP32) with a scoreboard fed by
// an arithmetic reference model of the IEEE packing rules.

module tb_fp_special_pack;

  localparam logic [1:0] C_NORMAL = 2'd0;
  localparam logic [1:0] C_ZERO   = 2'd1;
  localparam logic [1:0] C_INF    = 2'd2;
  localparam logic [1:0] C_NAN    = 2'd3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_special = C_NORMAL;
  logic        in_sign = 1'b0;
  logic [9:0]  in_exp = '0;
  logic [23:0] in_mant = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic [2:0]  out_flags;

  int n_cmp = 0;
  int n_err = 0;
  int accepted = 0;
  int emitted = 0;
  bit saw_full = 0;
  bit prev_stall = 0;
  logic [31:0] prev_data;
  logic [2:0]  prev_flags;
  logic [34:0] exp_q[$];

  fp_special_pack dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_special(in_special), .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_flags(out_flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  // Reference: {flags, word} from the packing rules using integer arithmetic.
  function automatic logic [34:0] model(input logic [1:0] sp, input logic sg, input int e, input int m);
    longint w;
    logic [2:0] f;
    f = 3'b000;
    w = longint'(sg) * 64'h8000_0000;
    if (sp == C_NAN) begin
      w = 64'h7FC0_0000;
      f = 3'b100;
    end else if (sp == C_INF) begin
      w = w + 255 * (64'd1 << 23);
    end else if (sp == C_ZERO || m == 0) begin
      w = w;
    end else if (e >= 255) begin
      w = w + 255 * (64'd1 << 23);
      f = 3'b010;
    end else if (e <= 0) begin
      f = 3'b001;
    end else begin
      w = w + longint'(e) * (64'd1 << 23) + longint'(m % (1 << 23));
    end
    return {f, w[31:0]};
  endfunction

  // Monitor/scoreboard, sampled mid-cycle while inputs are stable.
  always @(negedge clk) begin
    logic [34:0] e;
    if (rst) begin
      exp_q.delete();
      prev_stall = 0;
    end else begin
      check("in_ready", in_ready, (exp_q.size() < 2) || out_ready);
      if (!in_ready) saw_full = 1;
      if (prev_stall) begin
        check("stall_valid", out_valid, 1);
        check("stall_data", out_data, prev_data);
        check("stall_flags", out_flags, prev_flags);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("spurious_out", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("sb_data", out_data, e[31:0]);
          check("sb_flags", out_flags, e[34:32]);
          emitted++;
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(in_special, in_sign, int'($signed(in_exp)), int'(in_mant)));
        accepted++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_flags = out_flags;
    end
  end

  task automatic rand_beat();
    int e;
    in_special = ($urandom_range(0, 1) == 0) ? C_NORMAL : 2'($urandom_range(0, 3));
    in_sign    = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 3))
      0: e = -int'($urandom_range(0, 20));
      1: e = int'($urandom_range(1, 254));
      2: e = int'($urandom_range(255, 400));
      default: e = int'($urandom_range(0, 1023)) - 512;
    endcase
    in_exp  = 10'(e);
    in_mant = ($urandom_range(0, 7) == 0) ? 24'd0 : {1'b1, 23'($urandom)};
  endtask

  // mode 0: stall cycles 3-5; mode 1: random ready and gaps; mode 2: always ready.
  task automatic stream(input int n_beats, input int n_cycles, input int mode);
    int base;
    int last_acc;
    base = accepted;
    last_acc = accepted;
    for (int c = 0; c < n_cycles; c++) begin
      @(posedge clk); #1;
      case (mode)
        0: out_ready = !(c >= 3 && c <= 5);
        1: out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = 1'b1;
      endcase
      if (accepted - base >= n_beats) in_valid = 1'b0;
      else if (!(in_valid && accepted == last_acc)) begin
        if (mode == 1 && $urandom_range(0, 3) == 0) in_valid = 1'b0;
        else begin
          rand_beat();
          in_valid = 1'b1;
        end
      end
      last_acc = accepted;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic directed(input logic [1:0] sp, input logic sg, input int e, input logic [23:0] m,
                          input logic [31:0] w, input logic [2:0] f);
    @(posedge clk); #1;
    out_ready = 1'b1;
    in_valid = 1'b1; in_special = sp; in_sign = sg; in_exp = 10'(e); in_mant = m;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("dir_lat1", out_valid, 0);
    @(posedge clk); #1;
    check("dir_valid", out_valid, 1);
    check("dir_data", out_data, w);
    check("dir_flags", out_flags, f);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      out_ready = 1'b1;
    end
  endtask

  initial begin
    int base_e;
    int base_a;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_flags", out_flags, 0);
    check("rst_ready", in_ready, 1);

    directed(C_NORMAL, 1'b0, 127, 24'h800000, 32'h3F80_0000, 3'b000);
    directed(C_NAN, 1'b1, 5, 24'h812345, 32'h7FC0_0000, 3'b100);
    directed(C_INF, 1'b1, 5, 24'h812345, 32'hFF80_0000, 3'b000);
    directed(C_NORMAL, 1'b0, 255, 24'hC00000, 32'h7F80_0000, 3'b010);
    directed(C_NORMAL, 1'b0, 300, 24'hC00000, 32'h7F80_0000, 3'b010);
    directed(C_NORMAL, 1'b1, 255, 24'hC00000, 32'hFF80_0000, 3'b010);
    directed(C_NORMAL, 1'b1, 0, 24'hC00000, 32'h8000_0000, 3'b001);
    directed(C_NORMAL, 1'b1, -5, 24'hC00000, 32'h8000_0000, 3'b001);
    directed(C_ZERO, 1'b1, 100, 24'hC00000, 32'h8000_0000, 3'b000);
    directed(C_NORMAL, 1'b1, 254, 24'hFFFFFF, 32'hFF7F_FFFF, 3'b000);
    directed(C_NORMAL, 1'b0, 1, 24'h800001, 32'h0080_0001, 3'b000);
    directed(C_NORMAL, 1'b0, 300, 24'h000000, 32'h0000_0000, 3'b000);
    directed(C_NORMAL, 1'b0, 511, 24'hC00000, 32'h7F80_0000, 3'b010);
    directed(C_NORMAL, 1'b0, -512, 24'hC00000, 32'h0000_0000, 3'b001);
    idle(3);

    base_e = emitted;
    base_a = accepted;
    saw_full = 0;
    stream(6, 12, 0);
    idle(4);
    check("stall_full_seen", saw_full, 1);
    check("stall_accepted", accepted - base_a, 6);
    check("stall_emitted", emitted - base_e, 6);
    check("stall_q_empty", exp_q.size(), 0);

    base_e = emitted;
    base_a = accepted;
    stream(8, 9, 2);
    @(negedge clk); #1;
    check("tput_accepted", accepted - base_a, 8);
    check("tput_emitted", emitted - base_e, 8);
    idle(4);

    stream(300, 400, 1);
    idle(6);
    check("rand_q_empty", exp_q.size(), 0);
    check("rand_balance", emitted, accepted);

    // Fill both stages, then reset with both beats in flight.
    base_a = accepted;
    for (int c = 0; c < 10 && accepted - base_a < 2; c++) begin
      @(posedge clk); #1;
      out_ready = 1'b0;
      if (!(in_valid && accepted == base_a + 1 && c > 0) || accepted == base_a) begin
        rand_beat();
        in_special = C_INF;
        in_valid = 1'b1;
      end
    end
    check("inflight_two", accepted - base_a, 2);
    in_valid = 1'b0;
    rst = 1'b1;
    base_e = emitted;
    @(posedge clk); #1;
    check("rst2_valid", out_valid, 0);
    check("rst2_data", out_data, 0);
    check("rst2_flags", out_flags, 0);
    check("rst2_ready", in_ready, 1);
    rst = 1'b0;
    idle(8);
    check("rst2_no_emit", emitted, base_e);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "timeout");
  end

endmodule
